// File: rtl/fir_pkg.sv
// Shared definitions for the FIR result streamer: data/address widths, FSM encoding
// and the wrapping address helper.
package fir_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Address arithmetic deliberately wraps modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/fir_stream_fifo.sv
// Small synchronous prefetch FIFO; simultaneous push and pop on a full FIFO is allowed.
module fir_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   occ_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Qualify pop/push against current occupancy.
    always_comb begin
        do_pop_s  = pop && (occ_r != '0);
        do_push_s = push && ((occ_r != (PTR_W+1)'(DEPTH)) || do_pop_s);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + (PTR_W+1)'(1);
                2'b01:   occ_r <= occ_r - (PTR_W+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign empty     = (occ_r == '0);
    assign full      = (occ_r == (PTR_W+1)'(DEPTH));
    assign occupancy = occ_r;

endmodule

// File: rtl/fir_result_streamer.sv
// Streams count bytes from base_addr of the sample memory as a valid/ready byte stream.
// Optional running checksum enabled by defining FIR_STREAMER_CHECKSUM_EN.
module fir_result_streamer
    import fir_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       checksum
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CMT_W = OCC_W + 2;

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              mem_re_r;
    logic              pend_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  emitted_r;

    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [DATA_W-1:0] head_s;
    logic [OCC_W-1:0]  occ_s;
    logic              pop_s;
    logic              last_s;
    logic              can_issue_s;
    logic [CNT_W-1:0]  next_issue_s;
    logic [CMT_W-1:0]  commit_s;

    fir_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_r),
        .wdata     (mem_data),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .occupancy (occ_s)
    );

    // mem_re is registered, so the issue decision looks one cycle ahead: it counts buffered
    // bytes, the byte landing this cycle and the read going out this cycle, less any pop.
    always_comb begin
        pop_s        = !fifo_empty_s && m_ready;
        last_s       = !fifo_empty_s && (emitted_r == cnt_r - CNT_W'(1));
        next_issue_s = issued_r + CNT_W'(mem_re_r);
        commit_s     = CMT_W'(occ_s) + CMT_W'(pend_r) + CMT_W'(mem_re_r) - CMT_W'(pop_s);
        can_issue_s  = (commit_s < CMT_W'(FIFO_DEPTH)) && (next_issue_s < cnt_r)
                       && !(fifo_full_s && !pop_s);
    end

    // Transfer FSM with issue/emit counters and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            mem_re_r   <= 1'b0;
            pend_r     <= 1'b0;
            base_r     <= '0;
            mem_addr_r <= '0;
            cnt_r      <= '0;
            issued_r   <= '0;
            emitted_r  <= '0;
        end else begin
            done_r   <= 1'b0;
            mem_re_r <= 1'b0;
            pend_r   <= mem_re_r;
            if (mem_re_r) begin
                issued_r <= issued_r + CNT_W'(1);
            end
            if (pop_s) begin
                emitted_r <= emitted_r + CNT_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r    <= base_addr;
                        cnt_r     <= {1'b0, count};
                        issued_r  <= '0;
                        emitted_r <= '0;
                        busy_r    <= 1'b1;
                        if (count == '0) begin
                            state_r <= ST_FIN;
                        end else begin
                            state_r    <= ST_FETCH;
                            mem_re_r   <= 1'b1;
                            mem_addr_r <= base_addr;
                        end
                    end
                end
                ST_FETCH: begin
                    if (can_issue_s) begin
                        mem_re_r   <= 1'b1;
                        mem_addr_r <= wrap_addr(base_r, next_issue_s[ADDR_W-1:0]);
                    end
                    if (mem_re_r && (next_issue_s == cnt_r)) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && last_s) begin
                        state_r <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef FIR_STREAMER_CHECKSUM_EN
    logic [15:0] sum_r;

    // Running sum of accepted bytes; cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            sum_r <= 16'd0;
        end else if (pop_s) begin
            sum_r <= sum_r + 16'(head_s);
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 16'd0;
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_re   = mem_re_r;
    assign mem_addr = mem_addr_r;
    assign m_valid  = !fifo_empty_s;
    assign m_data   = fifo_empty_s ? {DATA_W{1'b0}} : head_s;
    assign m_last   = last_s;

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed self-checking bench for fir_result_streamer (checksum expectations follow
// FIR_STREAMER_CHECKSUM_EN).
module tb_fir_result_streamer;

`ifdef FIR_STREAMER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  count = '0;
    logic        busy, done, mem_re, m_valid, m_last;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  m_data;
    logic        m_ready = 1'b1;
    logic [15:0] checksum;

    logic [7:0]  mem [1024];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int cyc = 0;
    int s_cyc = 0;
    int n_rd, n_hs, n_done, n_busy, n_valid, n_unstable, max_out, done_cyc;
    int rd_addr [$];
    int hs_data [$];
    int hs_last [$];
    int hs_cyc  [$];
    bit stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    fir_result_streamer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_data  (mem_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_data <= mem[mem_addr];
    end

    // Monitor: records reads, handshakes and control events tagged with the cycle number.
    always @(posedge clk) begin
        if (mem_re) begin
            rd_addr.push_back(int'(mem_addr));
            n_rd++;
        end
        if (m_valid && m_ready) begin
            hs_data.push_back(int'(m_data));
            hs_last.push_back(int'(m_last));
            hs_cyc.push_back(cyc);
            n_hs++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) n_busy++;
        if (m_valid) n_valid++;
        if (stall_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last)) n_unstable++;
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_rd = 0; n_hs = 0; n_done = 0; n_busy = 0; n_valid = 0;
        n_unstable = 0; max_out = 0; done_cyc = -1;
        rd_addr.delete(); hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    endtask

    task automatic start_xfer(input int b, input int c);
        @(negedge clk);
        base_addr = 10'(b);
        count     = 10'(c);
        start     = 1'b1;
        s_cyc     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        int k = 0;
        while (n_done == 0 && k < 200) begin
            @(negedge clk);
            if (toggle) m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
        end
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 64'(n_done), 64'd1);
    endtask

    task automatic chk_stream(input string tag, input int first, input int n);
        chk({tag, "_nbytes"}, 64'(hs_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(hs_data[i]), 64'(first + i));
            chk($sformatf("%s_last%0d", tag, i), 64'(hs_last[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 5; i++) mem[100 + i] = 8'(5 + i);
        for (int i = 0; i < 8; i++) mem[200 + i] = 8'(10 + i);
        mem[1022] = 8'd1; mem[1023] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
        clear_mon();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, mem_re, mem_addr, m_valid, m_data, m_last, checksum}, 64'd0);
        rst = 1'b0;

        // 1: basic stream with m_ready high
        clear_mon();
        start_xfer(100, 5);
        wait_done("t1", 1'b0);
        chk_stream("t1", 5, 5);
        chk("t1_first_cyc", 64'(hs_cyc[0] - s_cyc), 64'd3);
        chk("t1_last_cyc", 64'(hs_cyc[4] - s_cyc), 64'd7);
        chk("t1_done_cyc", 64'(done_cyc - s_cyc), 64'd9);
        chk("t1_nreads", 64'(n_rd), 64'd5);
        chk("t1_checksum", 64'(checksum), CK_EN ? 64'd35 : 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // 2: backpressure pattern 1,0,0,1
        clear_mon();
        start_xfer(100, 5);
        wait_done("t2", 1'b1);
        chk_stream("t2", 5, 5);
        chk("t2_stable", 64'(n_unstable), 64'd0);
        chk("t2_outstanding_le4", 64'(max_out <= 4), 64'd1);
        chk("t2_checksum", 64'(checksum), CK_EN ? 64'd35 : 64'd0);

        // 3: zero-length transfer
        clear_mon();
        start_xfer(100, 0);
        wait_done("t3", 1'b0);
        chk("t3_nreads", 64'(n_rd), 64'd0);
        chk("t3_nvalid", 64'(n_valid), 64'd0);
        chk("t3_done_cyc", 64'(done_cyc - s_cyc), 64'd2);
        chk("t3_busy_cycles", 64'(n_busy), 64'd1);

        // 4: address wrap
        clear_mon();
        start_xfer(1022, 4);
        wait_done("t4", 1'b0);
        chk_stream("t4", 1, 4);
        chk("t4_nreads", 64'(rd_addr.size()), 64'd4);
        chk("t4_addr0", 64'(rd_addr[0]), 64'd1022);
        chk("t4_addr1", 64'(rd_addr[1]), 64'd1023);
        chk("t4_addr2", 64'(rd_addr[2]), 64'd0);
        chk("t4_addr3", 64'(rd_addr[3]), 64'd1);
        chk("t4_checksum", 64'(checksum), CK_EN ? 64'd10 : 64'd0);

        // 5: reset mid-transfer, then restart
        clear_mon();
        start_xfer(200, 8);
        for (int k = 0; k < 50 && n_hs < 2; k++) @(negedge clk);
        chk("t5_two_bytes", 64'(n_hs), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_reset_outputs", {busy, done, mem_re, mem_addr, m_valid, m_data, m_last, checksum}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_done", 64'(n_done), 64'd0);
        clear_mon();
        start_xfer(200, 8);
        wait_done("t5", 1'b0);
        chk_stream("t5", 10, 8);
        chk("t5_checksum", 64'(checksum), CK_EN ? 64'd108 : 64'd0);

        // 6: start while busy is ignored
        clear_mon();
        start_xfer(100, 5);
        @(negedge clk);
        base_addr = 10'd200;
        count     = 10'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6", 1'b0);
        chk_stream("t6", 5, 5);
        chk("t6_nreads", 64'(n_rd), 64'd5);
        chk("t6_addr4", 64'(rd_addr[4]), 64'd104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
